// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM states, default timing, parity helper.
// Used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FAIL
  } ps2_state_t;

  localparam int PS2_INHIBIT_CYCLES = 2600;
  localparam int PS2_START_SETUP    = 25;
  localparam int PS2_TIMEOUT_CYCLES = 375000;
  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_WDOG_W         = 19;

  function automatic logic odd_par(
    input logic [7:0] b
  );
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Glitch filter for one PS/2 line plus a falling-edge pulse
// on the filtered level.
module ps2_line_filter #(
  parameter int LEN = 8
) (
  input  logic clk_25MHz,
  input  logic clr,
  input  logic line,
  output logic filt,
  output logic fall
);

  logic [LEN-1:0] sr;
  logic           prev;

  always_ff @(posedge clk_25MHz or posedge clr) begin
    if (clr) begin
      sr   <= '1;
      filt <= 1'b1;
      prev <= 1'b1;
    end else begin
      sr   <= {sr[LEN-2:0], line};
      prev <= filt;
      if (&sr)
        filt <= 1'b1;
      else if (~|sr)
        filt <= 1'b0;
    end
  end

  assign fall = prev & ~filt;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send,
// device-clocked shift of data/parity/stop, ACK check, watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int START_SETUP    = PS2_START_SETUP,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
  input  logic       clk_25MHz,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int W = PS2_WDOG_W;
  localparam logic [W-1:0] INH_LAST = W'(INHIBIT_CYCLES - 1);
  localparam logic [W-1:0] SET_LAST = W'(START_SETUP - 1);
  localparam logic [W-1:0] TMO_LAST = W'(TIMEOUT_CYCLES - 1);

  ps2_state_t     state, state_n;
  logic [W-1:0]   cnt, cnt_n;
  logic [3:0]     n, n_n;
  logic [9:0]     sh, sh_n;
  logic           c_oe, c_oe_n;
  logic           d_oe, d_oe_n;
  logic           done_q, done_n;
  logic           c_filt, c_fall;
  logic           d_filt, d_fall_unused;
  logic           wd_run;

  ps2_line_filter #(.LEN(FILTER_LEN)) u_cfilt (
    .clk_25MHz (clk_25MHz),
    .clr       (clr),
    .line      (PS2C),
    .filt      (c_filt),
    .fall      (c_fall)
  );

  ps2_line_filter #(.LEN(FILTER_LEN)) u_dfilt (
    .clk_25MHz (clk_25MHz),
    .clr       (clr),
    .line      (PS2D),
    .filt      (d_filt),
    .fall      (d_fall_unused)
  );

  always_ff @(posedge clk_25MHz or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      n      <= '0;
      sh     <= '0;
      c_oe   <= 1'b0;
      d_oe   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      n      <= n_n;
      sh     <= sh_n;
      c_oe   <= c_oe_n;
      d_oe   <= d_oe_n;
      done_q <= done_n;
    end
  end

  assign wd_run = (state == SHIFT) ||
                  (state == ACK) ||
                  (state == WAIT_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    n_n     = n;
    sh_n    = sh;
    c_oe_n  = c_oe;
    d_oe_n  = d_oe;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sh_n    = {1'b1, odd_par(din), din};
          c_oe_n  = 1'b1;
          d_oe_n  = 1'b0;
          cnt_n   = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt == INH_LAST) begin
          d_oe_n  = 1'b1;
          cnt_n   = '0;
          state_n = RTS;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RTS: begin
        if (cnt == SET_LAST) begin
          c_oe_n  = 1'b0;
          cnt_n   = '0;
          n_n     = '0;
          state_n = SHIFT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHIFT: begin
        // sh holds {stop, par, data}; bit 0 is next on the wire
        if (c_fall) begin
          d_oe_n = ~sh[0];
          sh_n   = {1'b1, sh[9:1]};
          n_n    = n + 1'b1;
          if (n == 4'd9)
            state_n = ACK;
        end
      end
      ACK: begin
        if (c_fall)
          state_n = d_filt ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (c_filt && d_filt) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      FAIL: begin
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // timeout overrides any edge seen in the same cycle
    if (wd_run) begin
      if (cnt != '1)
        cnt_n = cnt + 1'b1;
      if (cnt == TMO_LAST) begin
        state_n = FAIL;
        c_oe_n  = 1'b0;
        d_oe_n  = 1'b0;
        done_n  = 1'b0;
      end
    end
  end

  assign ps2c_oe = c_oe;
  assign ps2d_oe = d_oe;
  assign busy    = (state != IDLE) && (state != FAIL);
  assign done    = done_q;
  assign err     = (state == FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on open-drain lines,
// bit and outcome scoreboards.
module tb_ps2_host_tx;

  localparam int TMO  = 24000;
  localparam int FAST = 40;
  localparam int SLOW = 1000;

  logic       clk_25MHz = 1'b0;
  logic       clr       = 1'b1;
  logic       start     = 1'b0;
  logic [7:0] din       = 8'h00;
  logic       dev_c     = 1'b1;
  logic       dev_d     = 1'b1;
  logic       PS2C, PS2D;
  logic       ps2c_oe, ps2d_oe;
  logic       busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;
  bit exp_q[$];
  int out_q[$];

  assign PS2C = dev_c & ~ps2c_oe;
  assign PS2D = dev_d & ~ps2d_oe;

  always #20 clk_25MHz = ~clk_25MHz;

  ps2_host_tx #(
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_25MHz (clk_25MHz),
    .clr       (clr),
    .start     (start),
    .din       (din),
    .PS2C      (PS2C),
    .PS2D      (PS2D),
    .ps2c_oe   (ps2c_oe),
    .ps2d_oe   (ps2d_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
  endtask

  // 1 = done, 2 = err
  initial forever begin
    @(negedge clk_25MHz);
    if (done || err) begin
      chk("done_err_excl", int'(done & err), 0);
      chk("pulse_expected", int'(out_q.size() > 0), 1);
      if (out_q.size() > 0)
        chk("outcome", done ? 1 : 2, out_q.pop_front());
    end
  end

  task automatic push_frame(
    input logic [7:0] b,
    input int         nbits
  );
    logic [9:0] fr;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      fr[i] = b[i];
      ones += int'(b[i]);
    end
    fr[8] = ((ones % 2) == 0);
    fr[9] = 1'b1;
    for (int i = 0; i < nbits; i++)
      exp_q.push_back(fr[i]);
  endtask

  task automatic device(
    input int half,
    input bit ack,
    input bit glitch,
    input int abort_at
  );
    int t;
    bit e;
    t = 0;
    while (!(PS2C === 1'b1 && PS2D === 1'b0) && t < 10000) begin
      @(negedge clk_25MHz);
      t++;
    end
    chk("rts_seen", int'(t < 10000), 1);
    repeat (half) @(negedge clk_25MHz);
    for (int k = 1; k <= 11; k++) begin
      dev_c = 1'b0;
      if (k == abort_at) begin
        repeat (half / 2) @(negedge clk_25MHz);
        dev_c = 1'b1;
        return;
      end
      repeat (half) @(negedge clk_25MHz);
      if (k <= 10) begin
        chk("bitq_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("bit%0d", k - 1), int'(PS2D), int'(e));
        end
      end
      dev_c = 1'b1;
      if (k == 10 && ack)
        dev_d = 1'b0;
      if (k == 11)
        dev_d = 1'b1;
      if (glitch && (k == 2 || k == 5 || k == 8)) begin
        repeat (half / 2) @(negedge clk_25MHz);
        dev_c = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        dev_c = 1'b1;
        repeat (half - half / 2 - 3) @(negedge clk_25MHz);
      end else begin
        repeat (half) @(negedge clk_25MHz);
      end
    end
  endtask

  task automatic host_timing(input logic [7:0] b);
    int t;
    chk("inh_start", int'(ps2c_oe), 1);
    t = 0;
    while (ps2c_oe && !ps2d_oe && t < 5000) begin
      if (t == 100) begin
        din   = ~b;
        start = 1'b1;
      end else if (t == 101) begin
        start = 1'b0;
      end
      @(negedge clk_25MHz);
      t++;
    end
    chk("inhibit_len", t, 2600);
    t = 0;
    while (ps2c_oe && ps2d_oe && t < 5000) begin
      @(negedge clk_25MHz);
      t++;
    end
    chk("setup_len", t, 25);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 40000) begin
      @(negedge clk_25MHz);
      t++;
    end
    chk(tag, int'(busy), 0);
    repeat (30) @(negedge clk_25MHz);
    chk("oe_released", int'({ps2c_oe, ps2d_oe}), 0);
    chk("outq_empty", out_q.size(), 0);
    chk("bitq_empty", exp_q.size(), 0);
  endtask

  task automatic xfer(
    input logic [7:0] b,
    input int         half,
    input bit         ack,
    input bit         glitch,
    input int         abort_at,
    input bit         timing
  );
    push_frame(b, (abort_at > 0) ? abort_at - 1 : 10);
    if (abort_at == 0)
      out_q.push_back(ack ? 1 : 2);
    @(negedge clk_25MHz);
    din   = b;
    start = 1'b1;
    @(negedge clk_25MHz);
    start = 1'b0;
    chk("busy_set", int'(busy), 1);
    fork
      begin
        if (timing)
          host_timing(b);
      end
      device(half, ack, glitch, abort_at);
    join
    if (abort_at > 0) begin
      chk("d_oe_before_clr", int'(ps2d_oe), 1);
      #5 clr = 1'b1;
      #1;
      chk("async_c_oe", int'(ps2c_oe), 0);
      chk("async_d_oe", int'(ps2d_oe), 0);
      chk("async_busy", int'(busy), 0);
      repeat (2) @(negedge clk_25MHz);
      clr = 1'b0;
    end
    wait_idle("busy_clear");
  endtask

  task automatic timeout_run();
    int t;
    out_q.push_back(2);
    @(negedge clk_25MHz);
    din   = 8'h55;
    start = 1'b1;
    @(negedge clk_25MHz);
    start = 1'b0;
    t = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && t < 5000) begin
      @(negedge clk_25MHz);
      t++;
    end
    chk("release_seen", int'(t < 5000), 1);
    t = 0;
    while (!err && t < TMO + 100) begin
      @(negedge clk_25MHz);
      t++;
    end
    chk("timeout_len", t, TMO);
    wait_idle("busy_after_tmo");
  endtask

  initial begin
    repeat (3) @(negedge clk_25MHz);
    chk("rst_c_oe", int'(ps2c_oe), 0);
    chk("rst_d_oe", int'(ps2d_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    clr = 1'b0;
    repeat (3) @(negedge clk_25MHz);
    chk("idle_busy", int'(busy), 0);

    xfer(8'hF4, SLOW, 1'b1, 1'b0, 0, 1'b1);
    xfer(8'hED, FAST, 1'b1, 1'b0, 0, 1'b0);
    xfer(8'h00, FAST, 1'b1, 1'b0, 0, 1'b0);
    xfer(8'h01, FAST, 1'b1, 1'b0, 0, 1'b0);
    xfer(8'hC3, FAST, 1'b0, 1'b0, 0, 1'b0);
    timeout_run();
    xfer(8'h5A, FAST, 1'b1, 1'b1, 0, 1'b0);
    xfer(8'hA5, FAST, 1'b1, 1'b0, 5, 1'b0);
    xfer(8'h3C, FAST, 1'b1, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to a keyboard/mouse over the shared open-drain PS2C/PS2D lines.
- Sits beside the PS/2 receiver. Performs the request-to-send sequence, then shifts data/parity/stop on device-generated clock edges, then checks the device ACK.
- Drives lines only through active-high pull-low enables; the pad level ties the line low when the enable is 1 and releases it otherwise.

Parameters:
- INHIBIT_CYCLES, 2600, clk_25MHz cycles PS2C is held low before the start bit (≥100 µs).
- START_SETUP, 25, cycles PS2D is held low with PS2C still low before PS2C is released.
- TIMEOUT_CYCLES, 375000, maximum cycles from PS2C release to ACK (15 ms).
- FILTER_LEN, 8, glitch-filter depth for the sampled PS2C/PS2D.

Ports:
- clk_25MHz  in  1  system clock, 25 MHz
- clr  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to send din
- din  in  8  command byte, sampled when start is accepted
- PS2C  in  1  raw PS/2 clock line level
- PS2D  in  1  raw PS/2 data line level
- ps2c_oe  out  1  1 = pull PS2C low
- ps2d_oe  out  1  1 = pull PS2D low
- busy  out  1  transfer in progress; the receiver ignores the bus while high
- done  out  1  one-cycle pulse: ACK received, bus idle
- err  out  1  one-cycle pulse: no ACK or timeout

Behaviour:
- Reset: clr is asynchronous, active-high; clock is clk_25MHz.
  - All outputs are 0 (both lines released). State is IDLE. Filters are preset to all-ones, so filtered lines read 1.
  - clr asserted mid-transfer releases both lines immediately. No done or err pulse is produced.
- Filters: each line is shifted into a FILTER_LEN-bit register every clock.
  - Filtered value becomes 1 on all-ones and 0 on all-zeros; otherwise it holds.
  - c_fall is a one-cycle pulse when filtered PS2C goes 1→0.
- Parity: odd parity, par = ~^byte.
- IDLE: start=1 latches din and par, then goes to INHIBIT with busy=1. start while busy is ignored.
- INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES. Then ps2d_oe=1 (start bit) and go to RTS.
- RTS: ps2c_oe=1 and ps2d_oe=1 for START_SETUP cycles. Then set ps2c_oe=0, clear bit counter n=0 and the watchdog, and go to SHIFT.
- SHIFT: on each c_fall, present the next bit and increment n.
  - c_fall #1..#8 present din[0]..din[7], LSB first.
  - c_fall #9 presents par.
  - c_fall #10 presents the stop bit, ps2d_oe=0.
  - Presenting bit b means ps2d_oe = ~b.
  - After #10, go to ACK.
- ACK: on the next c_fall (#11), sample filtered PS2D.
  - 0 = ACK: go to WAIT_IDLE.
  - 1: go to FAIL.
- WAIT_IDLE: when filtered PS2C=1 and PS2D=1, pulse done, clear busy, go to IDLE.
- FAIL: pulse err, clear busy, both enables 0, go to IDLE.
- Watchdog: counts every cycle in SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES-1 forces FAIL. A timeout takes priority over a c_fall in the same cycle.
  - 19-bit counter, saturating.
- The filter adds 8-9 cycles of latency from a PS2C edge to the ps2d_oe update. This is well inside the device's clock-low half period (≥30 µs).
- done and err are never asserted in the same cycle, and each is asserted at most once per accepted start.

Decomposition:
- Package ps2_pkg:
  - state encoding: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE, FAIL
  - default timing constants
  - shared with the receiver
- Sub-module ps2_line_filter: FILTER_LEN glitch filter plus falling-edge pulse, instantiated once per line.
  - The receiver migrates to it.

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz.
  - PS2C is held low for exactly 2600 cycles, then PS2D goes low 25 cycles before PS2C is released.
  - Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Device ACKs; done pulses once and busy falls.
- Send 0xED and 0x00.
  - Parity bits are 1 and 1.
  - 0x01 yields parity 0.
- Device never ACKs: PS2D stays high at the 11th falling edge -> err pulses, both enables are 0, busy=0.
- Device never clocks after the start bit -> err pulses exactly TIMEOUT_CYCLES after PS2C release.
- Inject 3-cycle glitches on PS2C during SHIFT -> no extra bit advance; byte is received intact.
- Assert clr at bit 5 -> ps2c_oe and ps2d_oe drop to 0 asynchronously, no done/err. A following start sends correctly.
